// File: rtl/uart_cmd_responder_if.sv
// UART byte link, register-port and status bundle for uart_cmd_responder.
// slave = responder side, master = UART/register-bank side.
interface uart_cmd_responder_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              busy;
  logic              err;

  modport slave (
    input  rx_data, rx_valid, tx_ready, mem_rdata,
    output tx_data, tx_wr, mem_addr, mem_wdata,
    output mem_we, mem_re, busy, err
  );

  modport master (
    output rx_data, rx_valid, tx_ready, mem_rdata,
    input  tx_data, tx_wr, mem_addr, mem_wdata,
    input  mem_we, mem_re, busy, err
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// UART command responder: W/R/P frames -> register port -> one reply byte.
// Define UART_CMD_CHECKSUM_EN to require a trailing XOR byte on W/R frames.
module uart_cmd_responder #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_cmd_responder_if.slave  bus
);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_P = 8'h50;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
  localparam logic [7:0] PONG = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
`ifdef UART_CMD_CHECKSUM_EN
    S_GET_CSUM,
`endif
    S_MEM_ACC,
    S_MEM_WAIT,
    S_SEND,
    S_SEND_HOLD
  } state_e;

  state_e          state_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic [7:0]      reply_q;
  logic [7:0]      tx_data_q;
  logic            is_w_q;
  logic            tx_wr_q;
  logic            mem_we_q;
  logic            mem_re_q;
  logic            err_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [1:0]      hold_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic in_frame;
  logic timeout;

`ifdef UART_CMD_CHECKSUM_EN
  assign in_frame = (state_q == S_GET_ADDR) ||
                    (state_q == S_GET_DATA) ||
                    (state_q == S_GET_CSUM);
`else
  assign in_frame = (state_q == S_GET_ADDR) ||
                    (state_q == S_GET_DATA);
`endif

  assign timeout = in_frame && !bus.rx_valid &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      reply_q   <= '0;
      tx_data_q <= '0;
      is_w_q    <= 1'b0;
      tx_wr_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
      hold_q    <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      tx_wr_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;

      if (in_frame && !bus.rx_valid)
        to_cnt_q <= to_cnt_q + 1'b1;
      else
        to_cnt_q <= '0;

      // half-duplex: bytes arriving while we own the link are dropped
      if (bus.rx_valid && !in_frame && state_q != S_IDLE)
        err_q <= 1'b1;

      unique case (state_q)
        S_IDLE: if (bus.rx_valid) begin
          is_w_q <= (bus.rx_data == OP_W);
`ifdef UART_CMD_CHECKSUM_EN
          csum_q <= bus.rx_data;
`endif
          unique case (1'b1)
            (bus.rx_data == OP_W),
            (bus.rx_data == OP_R): state_q <= S_GET_ADDR;
            (bus.rx_data == OP_P): begin
              reply_q <= PONG;
              state_q <= S_SEND;
            end
            default: begin
              reply_q <= NAK;
              err_q   <= 1'b1;
              state_q <= S_SEND;
            end
          endcase
        end
        S_GET_ADDR: if (bus.rx_valid) begin
          addr_q <= bus.rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          csum_q  <= csum_q ^ bus.rx_data;
          state_q <= is_w_q ? S_GET_DATA : S_GET_CSUM;
`else
          if (is_w_q) begin
            state_q <= S_GET_DATA;
          end else begin
            mem_re_q <= 1'b1;
            state_q  <= S_MEM_ACC;
          end
`endif
        end
        S_GET_DATA: if (bus.rx_valid) begin
          data_q <= bus.rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          csum_q  <= csum_q ^ bus.rx_data;
          state_q <= S_GET_CSUM;
`else
          mem_we_q <= 1'b1;
          state_q  <= S_MEM_ACC;
`endif
        end
`ifdef UART_CMD_CHECKSUM_EN
        S_GET_CSUM: if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            mem_we_q <= is_w_q;
            mem_re_q <= !is_w_q;
            state_q  <= S_MEM_ACC;
          end else begin
            reply_q <= NAK;
            err_q   <= 1'b1;
            state_q <= S_SEND;
          end
        end
`endif
        S_MEM_ACC: begin
          if (is_w_q) begin
            reply_q <= ACK;
            state_q <= S_SEND;
          end else begin
            state_q <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          reply_q <= bus.mem_rdata;
          state_q <= S_SEND;
        end
        S_SEND: if (bus.tx_ready) begin
          tx_data_q <= reply_q;
          tx_wr_q   <= 1'b1;
          hold_q    <= '0;
          state_q   <= S_SEND_HOLD;
        end
        S_SEND_HOLD: begin
          // transmitter drops tx_ready late, so skip two cycles first
          if (hold_q != 2'd2)
            hold_q <= hold_q + 1'b1;
          else if (bus.tx_ready)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (timeout) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
      end
    end
  end

  generate
    if (ADDR_W > 8) begin : g_addr_ext
      assign bus.mem_addr = {{(ADDR_W-8){1'b0}}, addr_q};
    end else if (ADDR_W == 8) begin : g_addr_eq
      assign bus.mem_addr = addr_q;
    end else begin : g_addr_trunc
      assign bus.mem_addr = addr_q[ADDR_W-1:0];
    end
  endgenerate

  assign bus.mem_wdata = data_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_wr     = tx_wr_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Randomized bench for uart_cmd_responder with a frame-level reference model.
// Build with +define+UART_CMD_CHECKSUM_EN to exercise checksummed frames.
module tb_uart_cmd_responder;

  localparam int TO = 200;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit HAS_CS = 1'b1;
`else
  localparam bit HAS_CS = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_responder_if #(.ADDR_W(8)) bus();

  uart_cmd_responder #(
    .ADDR_W(8),
    .TIMEOUT_CYCLES(TO),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  tx_q[$];
  logic [15:0] we_q[$];
  int          re_cnt = 0;
  longint      tx_t = 0;
  longint      rx_t = 0;
  bit          exp_err = 1'b0;
  bit          bp_low = 1'b0;
  bit          bp_rand = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
  end

  // register bank: one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge clk) begin
    bus.tx_ready = bp_low ? 1'b0 :
                   (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (bus.tx_wr) begin
      tx_q.push_back(bus.tx_data);
      tx_t = $time;
    end
    if (bus.mem_we) we_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.mem_re) re_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rx_t = $time;
  endtask

  task automatic wait_tx(input int n0);
    for (int i = 0; i < 2000; i++) begin
      if (tx_q.size() > n0) break;
      @(negedge clk);
    end
    chk("tx_seen", (tx_q.size() > n0), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    chk("idle", bus.busy, 0);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_tx_wr", bus.tx_wr, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
  endtask

  function automatic bq_t mk(input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] d);
    bq_t f;
    logic [7:0] x;
    f.push_back(op);
    if (op == 8'h57 || op == 8'h52) f.push_back(a);
    if (op == 8'h57) f.push_back(d);
    if (HAS_CS && (op == 8'h57 || op == 8'h52)) begin
      x = 8'h00;
      foreach (f[i]) x ^= f[i];
      f.push_back(x);
    end
    return f;
  endfunction

  // Model: decide reply, memory effect and error from the whole frame.
  task automatic do_frame(input bq_t f, input bit lat_chk);
    int         ntx, nwe, nre;
    logic [7:0] op, a, d, x, exp_reply;
    bit         cs_ok, exp_we, exp_re;
    ntx = tx_q.size();
    nwe = we_q.size();
    nre = re_cnt;
    op = f[0];
    a = 8'h00;
    d = 8'h00;
    exp_we = 1'b0;
    exp_re = 1'b0;
    cs_ok = 1'b1;
    if (HAS_CS && (op == 8'h57 || op == 8'h52)) begin
      x = 8'h00;
      for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
      cs_ok = (x == f[f.size()-1]);
    end
    if (op == 8'h57 && cs_ok) begin
      a = f[1];
      d = f[2];
      exp_reply = 8'h06;
      exp_we = 1'b1;
    end else if (op == 8'h52 && cs_ok) begin
      a = f[1];
      exp_reply = ref_mem[a];
      exp_re = 1'b1;
    end else if (op == 8'h50) begin
      exp_reply = 8'h55;
    end else begin
      exp_reply = 8'h15;
      exp_err = 1'b1;
    end
    foreach (f[i]) send_byte(f[i]);
    wait_tx(ntx);
    if (tx_q.size() > ntx) chk("reply", tx_q[ntx], exp_reply);
    if (lat_chk && exp_re)
      chk("rd_latency", 32'((tx_t - rx_t) / 10), 3);
    wait_idle();
    chk("tx_count", tx_q.size() - ntx, 1);
    chk("we_count", we_q.size() - nwe, exp_we);
    if (exp_we && we_q.size() > nwe)
      chk("we_addr_data", we_q[nwe], {a, d});
    chk("re_count", re_cnt - nre, exp_re);
    chk("err", bus.err, exp_err);
    if (exp_we) ref_mem[a] = d;
  endtask

  initial begin
    logic [7:0] op, a, d;
    int         ntx, nwe, k;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero();

    do_frame(mk(8'h57, 8'h10, 8'hA5), 1'b1);
    do_frame(mk(8'h52, 8'h10, 8'h00), 1'b1);
    do_frame(mk(8'h50, 8'h00, 8'h00), 1'b1);
    do_frame(mk(8'h3F, 8'h00, 8'h00), 1'b1);

    // inter-byte timeout mid write frame
    ntx = tx_q.size();
    nwe = we_q.size();
    send_byte(8'h57);
    send_byte(8'h20);
    repeat (TO - 2) @(negedge clk);
    chk("to_still_busy", bus.busy, 1);
    repeat (4) @(negedge clk);
    chk("to_idle", bus.busy, 0);
    exp_err = 1'b1;
    chk("to_err", bus.err, exp_err);
    chk("to_no_tx", tx_q.size() - ntx, 0);
    chk("to_no_we", we_q.size() - nwe, 0);
    do_frame(mk(8'h50, 8'h00, 8'h00), 1'b1);

    // transmitter backpressure
    ntx = tx_q.size();
    bp_low = 1'b1;
    @(negedge clk);
    send_byte(8'h50);
    repeat (500) @(negedge clk);
    chk("bp_no_tx", tx_q.size() - ntx, 0);
    chk("bp_busy", bus.busy, 1);
    bp_low = 1'b0;
    wait_tx(ntx);
    if (tx_q.size() > ntx) chk("bp_reply", tx_q[ntx], 8'h55);
    wait_idle();
    chk("bp_tx_count", tx_q.size() - ntx, 1);

    // reset mid-frame, then a stray data byte is parsed as an opcode
    send_byte(8'h57);
    send_byte(8'h30);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    chk_outputs_zero();
    do_frame(mk(8'h44, 8'h00, 8'h00), 1'b1);

    // byte received while the reply is pending is dropped
    ntx = tx_q.size();
    bp_low = 1'b1;
    @(negedge clk);
    send_byte(8'h50);
    repeat (5) @(negedge clk);
    send_byte(8'h12);
    exp_err = 1'b1;
    chk("hd_err", bus.err, exp_err);
    bp_low = 1'b0;
    wait_tx(ntx);
    if (tx_q.size() > ntx) chk("hd_reply", tx_q[ntx], 8'h55);
    wait_idle();
    chk("hd_tx_count", tx_q.size() - ntx, 1);

    if (HAS_CS) begin
      bq_t f;
      do_frame('{8'h57, 8'h01, 8'h02, 8'h54}, 1'b1);
      f = '{8'h57, 8'h01, 8'h02, 8'h00};
      do_frame(f, 1'b1);
    end

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      bp_rand = ($urandom_range(0, 1) == 1);
      k = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if (k < 4) op = 8'h57;
      else if (k < 8) op = 8'h52;
      else if (k == 8) op = 8'h50;
      else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52 || op == 8'h50)
          op = 8'($urandom);
      end
      do_frame(mk(op, a, d), !bp_rand);
    end
    bp_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Command responder on the far side of the UART byte link. It consumes received bytes (RX_ready/DOUT from the UART) and parses fixed-format command frames.
- It performs register-file reads and writes over a simple synchronous memory port, then returns one reply byte through the UART transmit interface (WR/DIN/TX_ready).
- It sits between the UART and the accelerator's control/status register bank, giving the host PC half-duplex read/write access.

Parameters:
- ADDR_W, 8, width of mem_addr; the address byte is truncated or zero-extended to this width.
- TIMEOUT_CYCLES, 1000000, maximum number of clk cycles allowed between bytes of one frame (about 10 byte-times at 100 MHz / 9600 baud).
- TO_W, 20, width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received byte, valid when rx_valid=1
- rx_valid  input  1  single-cycle pulse, one per received byte
- tx_data  output  8  reply byte to the UART transmitter
- tx_wr  output  1  single-cycle write strobe to the UART transmitter
- tx_ready  input  1  high when the UART transmitter is idle
- mem_addr  output  ADDR_W  register address
- mem_wdata  output  8  write data
- mem_we  output  1  single-cycle write enable
- mem_re  output  1  single-cycle read enable
- mem_rdata  input  8  read data, valid exactly one cycle after mem_re
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky error flag; cleared only by rst

Behaviour:
- Reset values: rst=1 sampled at a clk edge forces state=IDLE, and all outputs go to 0 (tx_data, tx_wr, mem_addr, mem_wdata, mem_we, mem_re, busy, err). The timeout counter is cleared. Reset mid-frame or mid-reply abandons the frame; a tx_wr already issued is not retracted.
- Frame formats (one byte per rx_valid pulse):
  - Write: 0x57, addr, data -> reply 0x06 (ACK).
  - Read: 0x52, addr -> reply mem[addr].
  - Ping: 0x50 -> reply 0x55.
  - Any other opcode -> reply 0x15 (NAK) and err:=1.
- States: IDLE, GET_ADDR, GET_DATA, GET_CSUM (macro only), MEM_ACC, MEM_WAIT, SEND, SEND_HOLD.
- IDLE:
  - rx_valid latches the opcode.
  - W or R -> GET_ADDR.
  - P or unknown -> SEND with the reply byte preloaded.
- GET_ADDR:
  - rx_valid latches the address.
  - W -> GET_DATA.
  - R -> MEM_ACC, or GET_CSUM under the macro.
- GET_DATA: rx_valid latches data -> MEM_ACC, or GET_CSUM under the macro.
- MEM_ACC:
  - Write: mem_we=1 for exactly one cycle with mem_addr/mem_wdata stable, reply=0x06 -> SEND.
  - Read: mem_re=1 for one cycle -> MEM_WAIT.
- MEM_WAIT: capture mem_rdata into the reply -> SEND. Read latency from the last frame byte to tx_wr is 3 cycles, assuming tx_ready=1.
- SEND:
  - When tx_ready=1, drive tx_data=reply and tx_wr=1 for one cycle -> SEND_HOLD.
  - tx_data holds its value until the next tx_wr.
- SEND_HOLD:
  - Ignore tx_ready for 2 cycles, because the transmitter deasserts TX_ready late.
  - Then wait for tx_ready=1 -> IDLE.
- Timeout:
  - In GET_ADDR, GET_DATA and GET_CSUM, the counter increments every cycle and clears on each rx_valid.
  - When it reaches TIMEOUT_CYCLES, go to IDLE, set err:=1, send no reply.
  - The counter is held at 0 in all other states.
- rx_valid arriving in MEM_ACC, MEM_WAIT, SEND or SEND_HOLD: the byte is dropped and err:=1 (half-duplex violation).
- rx_valid and a timeout in the same cycle: rx_valid wins.
- Address and data registers are 8-bit. mem_addr is zero-extended when ADDR_W>8 and takes the low bits when ADDR_W<8.

Optional Feature:
- Macro UART_CMD_CHECKSUM_EN.
- Defined:
  - W and R frames carry one trailing byte, the XOR of all preceding frame bytes, received in GET_CSUM.
  - Match -> MEM_ACC.
  - Mismatch -> no memory access, reply 0x15, err:=1.
  - Ping and unknown opcodes carry no checksum.
- Undefined: GET_CSUM does not exist and frames are exactly as listed above.

Test Plan:
- Write then read: rx bytes 0x57,0x10,0xA5 -> one mem_we pulse with addr=0x10, wdata=0xA5; tx_data=0x06. Then 0x52,0x10 with the model returning 0xA5 -> mem_re pulse; tx_data=0xA5 exactly 3 cycles after the second byte.
- Ping and NAK: 0x50 -> tx_data=0x55, err=0. Then 0x3F -> tx_data=0x15, err=1 and stays 1.
- Timeout: send 0x57,0x20, then silence for TIMEOUT_CYCLES -> back to IDLE, busy=0, err=1, no mem_we, no tx_wr. A following 0x50 is still answered with 0x55.
- Transmitter backpressure: hold tx_ready=0 for 500 cycles during a ping -> tx_wr not asserted until tx_ready=1, then exactly one tx_wr pulse.
- Reset mid-frame: after 0x57,0x30, pulse rst -> all outputs 0. Then 0x44 (data byte) -> treated as an opcode and answered with NAK 0x15; no write occurs.
- Checksum (macro defined): 0x57,0x01,0x02,0x54 -> write and ACK 0x06. 0x57,0x01,0x02,0x00 -> no mem_we, tx_data=0x15, err=1.
